// File: rtl/div.sv
// Multi-cycle 32-bit restoring radix-2 divider for DIV/DIVU with sign
// pre/post-correction, divide-by-zero shortcut and in-flight annul.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   dvsr;
  logic                neg_quo;
  logic                neg_rem;
  logic                accept;
  logic                iterate;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    if (is_signed && (v < 0)) return -v;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept  = (state == ST_FREE) && start_i && !annul_i && (opdata2_i != '0);
  assign iterate = (state == ST_ON) && !annul_i && (cnt != 6'd32);

  // Restoring step: bring in the next dividend bit, trial-subtract the divisor.
  // The remainder is always below the divisor, so the shifted value fits in 33 bits.
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvsr};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          state_nxt = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: state_nxt = ST_END;
      ST_ON: begin
        if (annul_i)             state_nxt = ST_FREE;
        else if (cnt == 6'd32)   state_nxt = ST_END;
      end
      ST_END: begin
        if (!start_i) state_nxt = ST_FREE;
      end
      default: state_nxt = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FREE;
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_FREE: begin
          cnt      <= '0;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
        ST_BYZERO: begin
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        ST_ON: begin
          if (annul_i) begin
            cnt <= '0;
          end else if (cnt == 6'd32) begin
            ready_o  <= 1'b1;
            result_o <= {cond_neg(rem, neg_rem), cond_neg(quo, neg_quo)};
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture at accept, then one quotient bit per cycle, MSB first.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvsr    <= magnitude(opdata2_i, signed_div_i);
      quo     <= magnitude(opdata1_i, signed_div_i);
      rem     <= '0;
      neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
    end else if (iterate) begin
      rem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// compared against a plain-arithmetic divide model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // {remainder, quotient}; division truncates toward zero, remainder takes
  // the dividend's sign. 64-bit arithmetic absorbs the MIN/-1 overflow case.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] uq;
    logic [31:0] ur;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just before the accept edge with start_i already high.
  // Latency is counted in rising edges after the accept edge.
  task automatic wait_result(input string tag, input logic [63:0] exp, input int lat,
                             input bit churn);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (churn) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = $urandom_range(0, 1);
      end
    end while (!ready_o && cyc < 40);
    chk({tag, " lat"}, 64'(cyc - 1), 64'(lat));
    chk({tag, " result"}, result_o, exp);
    @(negedge clk);
    chk({tag, " hold rdy"}, 64'(ready_o), 64'd1);
    chk({tag, " hold res"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, " drop rdy"}, 64'(ready_o), 64'd0);
    chk({tag, " drop res"}, result_o, 64'd0);
  endtask

  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit churn);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    wait_result(tag, exp, (b == 32'd0) ? 1 : 33, churn);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    bit          seen_rdy;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset rdy", 64'(ready_o), 64'd0);
    chk("reset res", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    do_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    do_div("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    do_div("u-7/2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 1'b0);
    do_div("u5/0", 1'b0, 32'd5, 32'd0, 64'd0, 1'b0);
    do_div("s5/0", 1'b1, 32'd5, 32'd0, 64'd0, 1'b0);
    do_div("s ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);

    // Annul at iteration 10: no ready pulse, then a fresh request runs full length.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    seen_rdy     = 1'b0;
    repeat (11) begin
      @(negedge clk);
      seen_rdy |= ready_o;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_rdy |= ready_o;
    end
    annul_i = 1'b0;
    repeat (36) begin
      @(negedge clk);
      seen_rdy |= ready_o;
    end
    chk("annul no rdy", 64'(seen_rdy), 64'd0);
    do_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

    // Reset mid-iteration with start held; new operands are resampled afterwards.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (15) @(negedge clk);
    rst          = 1'b1;
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFF9C;
    opdata2_i    = 32'd7;
    @(negedge clk);
    chk("rst midON rdy", 64'(ready_o), 64'd0);
    chk("rst midON res", result_o, 64'd0);
    rst = 1'b0;
    wait_result("after rst", 64'hFFFFFFFE_FFFFFFF2, 33, 1'b0);

    // start+annul together in FREE must not accept; latency is counted from release.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd6;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    wait_result("start+annul", 64'h00000002_00000008, 33, 1'b0);

    do_div("churn u", 1'b0, 32'hDEADBEEF, 32'd1234, ref_div(1'b0, 32'hDEADBEEF, 32'd1234), 1'b1);
    do_div("churn s", 1'b1, 32'h8000_0001, 32'hFFFF_FFF3, ref_div(1'b1, 32'h8000_0001, 32'hFFFF_FFF3), 1'b1);

    for (int i = 0; i < 14; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(1, 20);
        1:       rb = -($urandom_range(1, 20));
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rs = $urandom_range(0, 1);
      do_div($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb), (i % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
